// File: rtl/uart_ex.sv
// uart_ex: UART transmitter plus 16x-oversampled receiver feeding an RX FIFO.
// Ports: clk_50m, reset_n (sync, active-low); din/wr_en -> tx/tx_busy;
//        rx -> rdy/dout (FIFO head), rdy_clr pops and clears the sticky
//        frame_err/parity_err/overrun flags.
module uart_ex #(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned RX_DEPTH  = 4
) (
    input  logic                 clk_50m,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 wr_en,
    output logic                 tx,
    output logic                 tx_busy,
    input  logic                 rx,
    output logic                 rdy,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] dout,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int unsigned TX_DIV = CLK_HZ / BAUD;
    localparam int unsigned RX_DIV = CLK_HZ / (16 * BAUD);
    localparam int TXC_W = $clog2(TX_DIV) + 1;
    localparam int RXC_W = $clog2(RX_DIV) + 1;
    localparam int AW    = $clog2(RX_DEPTH);

    localparam logic [TXC_W-1:0] TX_LAST   = TXC_W'(TX_DIV - 1);
    localparam logic [RXC_W-1:0] RX_LAST   = RXC_W'(RX_DIV - 1);
    localparam logic [2:0]       LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic             ODD       = (PARITY == 1);
    localparam logic             HAS_PAR   = (PARITY != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t               tx_state, tx_state_n;
    logic [TXC_W-1:0]     tx_cnt, tx_cnt_n;
    logic [2:0]           tx_bit, tx_bit_n;
    logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
    logic                 tx_par, tx_par_n;
    logic                 tx_end;

    always_ff @(posedge clk_50m) begin
        if (!reset_n) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_sh    <= tx_sh_n;
            tx_par   <= tx_par_n;
        end
    end

    assign tx_end = (tx_cnt == TX_LAST);

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_sh_n    = tx_sh;
        tx_par_n   = tx_par;
        tx         = 1'b1;
        tx_busy    = (tx_state != S_IDLE);
        if (tx_state != S_IDLE) begin
            tx_cnt_n = tx_end ? '0 : tx_cnt + 1'b1;
        end
        unique case (tx_state)
            S_IDLE: begin
                if (wr_en) begin
                    tx_state_n = S_START;
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_sh_n    = din;
                    // even: parity = xor of data; odd: its complement
                    tx_par_n   = (^din) ^ ODD;
                end
            end
            S_START: begin
                tx = 1'b0;
                if (tx_end) begin
                    tx_state_n = S_DATA;
                end
            end
            S_DATA: begin
                tx = tx_sh[0];
                if (tx_end) begin
                    tx_sh_n = tx_sh >> 1;
                    if (tx_bit == LAST_DATA) begin
                        tx_bit_n   = '0;
                        tx_state_n = HAS_PAR ? S_PARITY : S_STOP;
                    end else begin
                        tx_bit_n = tx_bit + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                tx = tx_par;
                if (tx_end) begin
                    tx_state_n = S_STOP;
                end
            end
            S_STOP: begin
                tx = 1'b1;
                if (tx_end) begin
                    if (tx_bit == LAST_STOP) begin
                        tx_bit_n   = '0;
                        tx_state_n = S_IDLE;
                    end else begin
                        tx_bit_n = tx_bit + 1'b1;
                    end
                end
            end
            default: begin
                tx_state_n = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receiver: synchronizer and 16x tick
    // ------------------------------------------------------------------
    logic             rx_m, rx_s;
    logic [RXC_W-1:0] div_cnt;
    logic             tick;

    always_ff @(posedge clk_50m) begin
        if (!reset_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= (div_cnt == RX_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == RX_LAST);

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    state_t               rx_state, rx_state_n;
    logic [3:0]           rx_tk, rx_tk_n;
    logic [2:0]           rx_bit, rx_bit_n;
    logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
    logic                 rx_pbad, rx_pbad_n;
    logic                 mid;
    logic                 push, fe_set, pe_set, ov_set;

    always_ff @(posedge clk_50m) begin
        if (!reset_n) begin
            rx_state <= S_IDLE;
            rx_tk    <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_pbad  <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            rx_tk    <= rx_tk_n;
            rx_bit   <= rx_bit_n;
            rx_sh    <= rx_sh_n;
            rx_pbad  <= rx_pbad_n;
        end
    end

    // rx_tk wraps naturally at 16, so after the start-bit midpoint
    // every wrap lands on the middle of the next bit
    assign mid = tick && (rx_tk == 4'd15);

    always_comb begin
        rx_state_n = rx_state;
        rx_tk_n    = rx_tk;
        rx_bit_n   = rx_bit;
        rx_sh_n    = rx_sh;
        rx_pbad_n  = rx_pbad;
        push       = 1'b0;
        fe_set     = 1'b0;
        pe_set     = 1'b0;
        if (tick && rx_state != S_IDLE) begin
            rx_tk_n = rx_tk + 1'b1;
        end
        unique case (rx_state)
            S_IDLE: begin
                if (!rx_s) begin
                    rx_state_n = S_START;
                    rx_tk_n    = '0;
                    rx_bit_n   = '0;
                    rx_pbad_n  = 1'b0;
                end
            end
            S_START: begin
                if (tick && rx_tk == 4'd7) begin
                    rx_tk_n    = '0;
                    rx_state_n = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (mid) begin
                    rx_sh_n = {rx_s, rx_sh[DATA_BITS-1:1]};
                    if (rx_bit == LAST_DATA) begin
                        rx_bit_n   = '0;
                        rx_state_n = HAS_PAR ? S_PARITY : S_STOP;
                    end else begin
                        rx_bit_n = rx_bit + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (mid) begin
                    rx_pbad_n  = rx_s != ((^rx_sh) ^ ODD);
                    rx_state_n = S_STOP;
                end
            end
            S_STOP: begin
                // only the first stop bit is checked; the FSM is back
                // in IDLE while any further stop bits are still on the line
                if (mid) begin
                    rx_state_n = S_IDLE;
                    fe_set     = !rx_s;
                    pe_set     = rx_pbad;
                    push       = rx_s && !rx_pbad;
                end
            end
            default: begin
                rx_state_n = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [RX_DEPTH];
    logic [AW:0]          wptr, rptr;
    logic                 empty, full, pop, wr;

    assign empty  = (wptr == rptr);
    assign full   = (wptr[AW] != rptr[AW]) &&
                    (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop    = rdy_clr && !empty;
    // a pop in the same cycle frees the slot being written
    assign wr     = push && (!full || pop);
    assign ov_set = push && full && !pop;

    always_ff @(posedge clk_50m) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50m) begin
        if (reset_n && wr) begin
            mem[wptr[AW-1:0]] <= rx_sh;
        end
    end

    assign rdy  = !empty;
    assign dout = empty ? '0 : mem[rptr[AW-1:0]];

    // sticky flags: a new event wins over a simultaneous clear
    always_ff @(posedge clk_50m) begin
        if (!reset_n) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= fe_set | (frame_err & ~rdy_clr);
            parity_err <= pe_set | (parity_err & ~rdy_clr);
            overrun    <= ov_set | (overrun & ~rdy_clr);
        end
    end

endmodule

// File: doc/uart_ex.md
UART_EX -- requirements
Module: uart_ex

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line rate in bit/s.
REQ-003 Parameter DATA_BITS, default 8, payload width; legal values 5..8.
REQ-004 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 Parameter STOP_BITS, default 1, number of stop bits: 1 or 2.
REQ-006 Parameter RX_DEPTH, default 4, RX FIFO entries; power of 2, at least 2.
REQ-007 clk_50m  in  1  sole clock; all logic on its rising edge.
REQ-008 reset_n  in  1  reset, synchronous, active-low.
REQ-009 din  in  DATA_BITS  TX byte, sampled on wr_en.
REQ-010 wr_en  in  1  TX request, one-cycle strobe.
REQ-011 tx  out  1  serial output, idle high.
REQ-012 tx_busy  out  1  high while a TX frame is in progress.
REQ-013 rx  in  1  serial input, asynchronous to clk_50m.
REQ-014 rdy  out  1  RX FIFO non-empty.
REQ-015 rdy_clr  in  1  pop the RX FIFO head; also clears sticky error flags.
REQ-016 dout  out  DATA_BITS  RX FIFO head; valid while rdy=1.
REQ-017 frame_err  out  1  sticky: a received frame had a low stop bit.
REQ-018 parity_err  out  1  sticky: a received frame failed the parity check.
REQ-019 overrun  out  1  sticky: a byte arrived while the FIFO was full.

Function
REQ-020 TX bit period SHALL be TX_DIV=CLK_HZ/BAUD cycles (integer division), counted by a free counter restarted at frame start.
REQ-021 RX tick SHALL occur every RX_DIV=CLK_HZ/(16*BAUD) cycles, giving 16x oversampling.
REQ-022 TX FSM states: IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-023 wr_en in IDLE SHALL latch din and enter START on the next cycle; tx_busy SHALL be high from that cycle until STOP completes.
REQ-024 wr_en while tx_busy=1 SHALL be ignored; no queuing.
REQ-025 Frame order: start bit 0, data LSB first, optional parity bit, STOP_BITS stop bits of 1; each bit lasts exactly TX_DIV cycles.
REQ-026 Parity bit: even mode makes the count of 1s over data+parity even; odd mode makes it odd.
REQ-027 rx SHALL pass through a 2-flop synchronizer before use.
REQ-028 RX FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-029 In IDLE, a synchronized low SHALL enter START; the line SHALL be resampled 8 ticks later; if high, return to IDLE with no effect (glitch reject).
REQ-030 After START, each subsequent bit SHALL be sampled at 16-tick intervals (mid-bit); only the first stop bit is checked on RX.
REQ-031 A low stop bit SHALL set frame_err and discard the byte; a parity mismatch SHALL set parity_err and discard the byte.
REQ-032 A good byte SHALL be pushed into the FIFO; rdy SHALL rise the cycle after the push.
REQ-033 rdy_clr with rdy=1 SHALL pop one entry; rdy_clr with rdy=0 SHALL not pop and SHALL still clear flags.
REQ-034 Push when full, with no pop in the same cycle: byte dropped, overrun set, FIFO contents unchanged.
REQ-035 Push and pop in the same cycle SHALL both take effect, including when full; no overrun in that case.
REQ-036 FIFO pointers SHALL be log2(RX_DEPTH)+1 bits wide with natural wrap-around.
REQ-037 An error event coinciding with rdy_clr SHALL leave its flag set (set wins over clear).

Reset
REQ-038 On a clk_50m edge with reset_n=0: tx=1, tx_busy=0, rdy=0, dout=0, all error flags 0, FIFO empty, both FSMs in IDLE, all counters 0.
REQ-039 Reset mid-frame SHALL abort the frame: tx returns to 1 on the next edge and partial RX data is discarded.

Verification
REQ-040 CLK_HZ=1600000, BAUD=100000, 8N1: wr_en with din=0xA5 -> tx shows 0,1,0,1,0,0,1,0,1,1, each 16 cycles; tx_busy high for 160 cycles.
REQ-041 Same config: loop tx to rx, send 0x3C -> rdy=1 and dout=0x3C; rdy_clr -> rdy=0.
REQ-042 PARITY=2: drive a 0x01 frame with parity bit 0 -> parity_err=1, rdy stays 0.
REQ-043 RX_DEPTH=4: receive 5 bytes without rdy_clr -> first 4 are read back in order, overrun=1.
REQ-044 A 4-cycle low pulse on idle rx -> no frame received, no flags set; a stop bit held low -> frame_err=1.
REQ-045 reset_n=0 asserted during TX bit 3 -> next edge shows tx=1 and tx_busy=0.
